inverse_quant_seq: RTL and testbench

Row sequencer for the inverse-quantisation stage of the residual path. It accepts one 4x4 (or 2x2 chroma DC) coefficient block on a start pulse and reads the block row by row from the upstream coefficient buffer. Each row is driven through an internal `transform_inverse_quant` instance with the correct counter, QP and DC substitution. Dequantised rows go to the inverse transform over a valid/ready handshake.

---
 rtl/iq_pkg.sv | 120 ++++++++++++
 rtl/transform_inverse_quant.sv | 71 +++++++
 rtl/inverse_quant_seq.sv | 216 +++++++++++++++++++++
 tb/tb_inverse_quant_seq.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/iq_pkg.sv
// Shared definitions for the inverse-quantisation row sequencer.
// Holds block_type codes, FSM state encoding, the output row payload and
// small helpers for block classification and the level-scale table.
package iq_pkg;

    localparam int unsigned COEF_W = 16;
    localparam int unsigned QP_W   = 6;
    localparam int unsigned BT_W   = 3;
    localparam int unsigned ROW_W  = 2;
    localparam int unsigned LS_W   = 5;

    localparam logic [BT_W-1:0] BT_I16_DC    = 3'd1;
    localparam logic [BT_W-1:0] BT_I16_AC    = 3'd2;
    localparam logic [BT_W-1:0] BT_LUMA4X4   = 3'd3;
    localparam logic [BT_W-1:0] BT_CHROMA_DC = 3'd5;
    localparam logic [BT_W-1:0] BT_CHROMA_AC = 3'd6;

    // Level-scale position classes within a 4x4 block
    localparam logic [1:0] LS_EVEN  = 2'd0;
    localparam logic [1:0] LS_ODD   = 2'd1;
    localparam logic [1:0] LS_MIXED = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_CALC = 2'd2,
        ST_OUT  = 2'd3
    } iq_state_t;

    // One dequantised row as presented to the inverse transform
    typedef struct packed {
        logic [ROW_W-1:0]  row;
        logic              last;
        logic [COEF_W-1:0] p_3;
        logic [COEF_W-1:0] p_2;
        logic [COEF_W-1:0] p_1;
        logic [COEF_W-1:0] p_0;
    } iq_row_t;

    function automatic logic bt_legal(input logic [BT_W-1:0] bt);
        return (bt == BT_I16_DC) || (bt == BT_I16_AC) || (bt == BT_LUMA4X4) ||
               (bt == BT_CHROMA_DC) || (bt == BT_CHROMA_AC);
    endfunction

    function automatic logic bt_is_chroma(input logic [BT_W-1:0] bt);
        return (bt == BT_CHROMA_DC) || (bt == BT_CHROMA_AC);
    endfunction

    // DC-only blocks scale every coefficient with the (0,0) level scale
    function automatic logic bt_is_dc(input logic [BT_W-1:0] bt);
        return (bt == BT_I16_DC) || (bt == BT_CHROMA_DC);
    endfunction

    // AC blocks whose (0,0) coefficient comes from the separate DC path
    function automatic logic bt_has_dc(input logic [BT_W-1:0] bt);
        return (bt == BT_I16_AC) || (bt == BT_CHROMA_AC);
    endfunction

    // Chroma DC is a 2x2 packed into row 0
    function automatic logic [ROW_W-1:0] bt_last_row(input logic [BT_W-1:0] bt);
        return (bt == BT_CHROMA_DC) ? 2'd0 : 2'd3;
    endfunction

    function automatic logic [1:0] ls_class(input logic row_odd, input logic col_odd);
        if (!row_odd && !col_odd) return LS_EVEN;
        if (row_odd && col_odd)   return LS_ODD;
        return LS_MIXED;
    endfunction

    // Level scale indexed by qp%6 and position class
    function automatic logic [LS_W-1:0] level_scale(input logic [2:0] m, input logic [1:0] cls);
        logic [LS_W-1:0] v;
        v = 5'd0;
        case (cls)
            LS_EVEN: begin
                case (m)
                    3'd0:    v = 5'd10;
                    3'd1:    v = 5'd11;
                    3'd2:    v = 5'd13;
                    3'd3:    v = 5'd14;
                    3'd4:    v = 5'd16;
                    default: v = 5'd18;
                endcase
            end
            LS_ODD: begin
                case (m)
                    3'd0:    v = 5'd16;
                    3'd1:    v = 5'd18;
                    3'd2:    v = 5'd20;
                    3'd3:    v = 5'd23;
                    3'd4:    v = 5'd25;
                    default: v = 5'd29;
                endcase
            end
            default: begin
                case (m)
                    3'd0:    v = 5'd13;
                    3'd1:    v = 5'd14;
                    3'd2:    v = 5'd16;
                    3'd3:    v = 5'd18;
                    3'd4:    v = 5'd20;
                    default: v = 5'd23;
                endcase
            end
        endcase
        return v;
    endfunction

    // Row produced without reading the buffer when the whole block is zero
    function automatic iq_row_t zero_row(input logic [BT_W-1:0] bt, input logic [ROW_W-1:0] row,
                                         input logic [COEF_W-1:0] dc);
        iq_row_t r;
        r      = '0;
        r.row  = row;
        r.last = (row == bt_last_row(bt));
        if (bt_has_dc(bt) && (row == 2'd0)) r.p_0 = dc;
        return r;
    endfunction

endpackage

// File: rtl/transform_inverse_quant.sv
// Combinational dequantiser for one coefficient row.
// Ports: i_block_type / i_qp / i_counter select the scale; i_p_in_0..3 are the
// signed row coefficients; o_p_out_0..3 the 16-bit dequantised results.
// Scaling: c * LS(qp%6, pos) << qp/6; luma DC then >>>2, chroma DC >>>1
// (DC blocks always use the (0,0) scale). For AC blocks with a separate DC,
// position (0,0) is passed through unchanged. Results wrap to 16 bits.
module transform_inverse_quant
    import iq_pkg::*;
(
    input  logic [BT_W-1:0]   i_block_type,
    input  logic [QP_W-1:0]   i_qp,
    input  logic [ROW_W-1:0]  i_counter,
    input  logic [COEF_W-1:0] i_p_in_0,
    input  logic [COEF_W-1:0] i_p_in_1,
    input  logic [COEF_W-1:0] i_p_in_2,
    input  logic [COEF_W-1:0] i_p_in_3,
    output logic [COEF_W-1:0] o_p_out_0,
    output logic [COEF_W-1:0] o_p_out_1,
    output logic [COEF_W-1:0] o_p_out_2,
    output logic [COEF_W-1:0] o_p_out_3
);

    localparam int unsigned PROD_W = 32;

    logic [2:0]        w_qp_mod;
    logic [3:0]        w_qp_div;
    logic [COEF_W-1:0] w_in  [4];
    logic [COEF_W-1:0] w_out [4];

    assign w_qp_div = 4'(i_qp / 6'd6);
    assign w_qp_mod = 3'(i_qp % 6'd6);

    assign w_in[0] = i_p_in_0;
    assign w_in[1] = i_p_in_1;
    assign w_in[2] = i_p_in_2;
    assign w_in[3] = i_p_in_3;

    function automatic logic [COEF_W-1:0] scale_coef(input logic [COEF_W-1:0] c,
                                                     input logic [LS_W-1:0]   ls,
                                                     input logic [3:0]        sh,
                                                     input logic [BT_W-1:0]   bt);
        logic signed [PROD_W-1:0] v;
        v = PROD_W'($signed(c)) * $signed(PROD_W'(ls));
        v = v <<< sh;
        if (bt == BT_I16_DC)         v = v >>> 2;
        else if (bt == BT_CHROMA_DC) v = v >>> 1;
        return v[COEF_W-1:0];
    endfunction

    // Per-column scale selection and DC passthrough
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_out[k] = '0;
            if (bt_has_dc(i_block_type) && (i_counter == 2'd0) && (k == 0)) begin
                w_out[k] = w_in[k];
            end else if (bt_is_dc(i_block_type)) begin
                w_out[k] = scale_coef(w_in[k], level_scale(w_qp_mod, LS_EVEN), w_qp_div, i_block_type);
            end else begin
                w_out[k] = scale_coef(w_in[k],
                                      level_scale(w_qp_mod, ls_class(i_counter[0], 1'(k % 2))),
                                      w_qp_div, i_block_type);
            end
        end
    end

    assign o_p_out_0 = w_out[0];
    assign o_p_out_1 = w_out[1];
    assign o_p_out_2 = w_out[2];
    assign o_p_out_3 = w_out[3];

endmodule

// File: rtl/inverse_quant_seq.sv
// Row sequencer for inverse quantisation of one coefficient block.
// Ports: start/block_type/qp_luma/qp_chroma/dc_in/all_zero describe a block
// (latched at start); coeff_rd_en/coeff_rd_row/coeff_rd_data_0..3 read the
// coefficient buffer (data one cycle after the strobe); out_valid/out_ready/
// out_row/out_last/out_p_0..3 carry dequantised rows; busy, done and err
// report block progress.
// Build option IQ_ZERO_SKIP_EN: blocks flagged all_zero bypass the buffer
// read and datapath, emitting zero rows (DC kept for AC-with-DC types).
module inverse_quant_seq
    import iq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [BT_W-1:0]   block_type,
    input  logic [QP_W-1:0]   qp_luma,
    input  logic [QP_W-1:0]   qp_chroma,
    input  logic [COEF_W-1:0] dc_in,
    input  logic              all_zero,
    output logic              coeff_rd_en,
    output logic [ROW_W-1:0]  coeff_rd_row,
    input  logic [COEF_W-1:0] coeff_rd_data_0,
    input  logic [COEF_W-1:0] coeff_rd_data_1,
    input  logic [COEF_W-1:0] coeff_rd_data_2,
    input  logic [COEF_W-1:0] coeff_rd_data_3,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ROW_W-1:0]  out_row,
    output logic              out_last,
    output logic [COEF_W-1:0] out_p_0,
    output logic [COEF_W-1:0] out_p_1,
    output logic [COEF_W-1:0] out_p_2,
    output logic [COEF_W-1:0] out_p_3,
    output logic              busy,
    output logic              done,
    output logic              err
);

    iq_state_t         r_state, w_nxt_state;
    logic [ROW_W-1:0]  r_row, w_nxt_row;
    logic [BT_W-1:0]   r_bt;
    logic [QP_W-1:0]   r_qp;
    logic [COEF_W-1:0] r_dc;
    iq_row_t           r_out, w_nxt_out;
    logic              r_rd_en, w_nxt_rd_en;
    logic [ROW_W-1:0]  r_rd_row;
    logic              r_out_valid, w_nxt_out_valid;
    logic              r_busy;
    logic              r_done, w_nxt_done;
    logic              r_err, w_nxt_err;
    logic              w_latch;
    logic              w_skip_start;
    logic              w_skip_blk;
    logic [COEF_W-1:0] w_dp_in_0;
    logic [COEF_W-1:0] w_dp_p_0, w_dp_p_1, w_dp_p_2, w_dp_p_3;

`ifdef IQ_ZERO_SKIP_EN
    logic r_zero;
    assign w_skip_start = all_zero;
    assign w_skip_blk   = r_zero;
`else
    logic w_unused_all_zero;
    assign w_unused_all_zero = all_zero;
    assign w_skip_start      = 1'b0;
    assign w_skip_blk        = 1'b0;
`endif

    // Row 0 of AC-with-DC blocks takes its (0,0) term from the latched DC
    assign w_dp_in_0 = (bt_has_dc(r_bt) && (r_row == 2'd0)) ? r_dc : coeff_rd_data_0;

    transform_inverse_quant u_tiq (
        .i_block_type (r_bt),
        .i_qp         (r_qp),
        .i_counter    (r_row),
        .i_p_in_0     (w_dp_in_0),
        .i_p_in_1     (coeff_rd_data_1),
        .i_p_in_2     (coeff_rd_data_2),
        .i_p_in_3     (coeff_rd_data_3),
        .o_p_out_0    (w_dp_p_0),
        .o_p_out_1    (w_dp_p_1),
        .o_p_out_2    (w_dp_p_2),
        .o_p_out_3    (w_dp_p_3)
    );

    // Next-state and next-output decode
    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_row       = r_row;
        w_nxt_out       = r_out;
        w_nxt_rd_en     = 1'b0;
        w_nxt_out_valid = 1'b0;
        w_nxt_done      = 1'b0;
        w_nxt_err       = 1'b0;
        w_latch         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (bt_legal(block_type)) begin
                        w_latch = 1'b1;
                        if (w_skip_start) begin
                            w_nxt_state     = ST_OUT;
                            w_nxt_out_valid = 1'b1;
                            w_nxt_out       = zero_row(block_type, 2'd0, dc_in);
                        end else begin
                            w_nxt_state = ST_RD;
                            w_nxt_rd_en = 1'b1;
                        end
                    end else begin
                        w_nxt_err = 1'b1;
                    end
                end
            end
            ST_RD: begin
                w_nxt_state = ST_CALC;
            end
            ST_CALC: begin
                w_nxt_state     = ST_OUT;
                w_nxt_out_valid = 1'b1;
                w_nxt_out.row   = r_row;
                w_nxt_out.last  = (r_row == bt_last_row(r_bt));
                w_nxt_out.p_0   = w_dp_p_0;
                w_nxt_out.p_1   = w_dp_p_1;
                w_nxt_out.p_2   = w_dp_p_2;
                w_nxt_out.p_3   = w_dp_p_3;
            end
            ST_OUT: begin
                w_nxt_out_valid = 1'b1;
                if (out_ready) begin
                    if (r_row == bt_last_row(r_bt)) begin
                        w_nxt_row       = '0;
                        w_nxt_state     = ST_IDLE;
                        w_nxt_out_valid = 1'b0;
                        w_nxt_done      = 1'b1;
                    end else begin
                        w_nxt_row = 2'(r_row + 2'd1);
                        if (w_skip_blk) begin
                            w_nxt_out = zero_row(r_bt, w_nxt_row, r_dc);
                        end else begin
                            w_nxt_state     = ST_RD;
                            w_nxt_out_valid = 1'b0;
                            w_nxt_rd_en     = 1'b1;
                        end
                    end
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase
    end

    // State and row counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_row   <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_row   <= w_nxt_row;
        end
    end

    // Block controls captured at start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bt <= '0;
            r_qp <= '0;
            r_dc <= '0;
`ifdef IQ_ZERO_SKIP_EN
            r_zero <= 1'b0;
`endif
        end else if (w_latch) begin
            r_bt <= block_type;
            r_qp <= bt_is_chroma(block_type) ? qp_chroma : qp_luma;
            r_dc <= dc_in;
`ifdef IQ_ZERO_SKIP_EN
            r_zero <= all_zero;
`endif
        end
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_en     <= 1'b0;
            r_rd_row    <= '0;
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_rd_en     <= w_nxt_rd_en;
            r_rd_row    <= w_nxt_row;
            r_out_valid <= w_nxt_out_valid;
            r_out       <= w_nxt_out;
            r_busy      <= (w_nxt_state != ST_IDLE);
            r_done      <= w_nxt_done;
            r_err       <= w_nxt_err;
        end
    end

    assign coeff_rd_en  = r_rd_en;
    assign coeff_rd_row = r_rd_row;
    assign out_valid    = r_out_valid;
    assign out_row      = r_out.row;
    assign out_last     = r_out.last;
    assign out_p_0      = r_out.p_0;
    assign out_p_1      = r_out.p_1;
    assign out_p_2      = r_out.p_2;
    assign out_p_3      = r_out.p_3;
    assign busy         = r_busy;
    assign done         = r_done;
    assign err          = r_err;

endmodule

// File: tb/tb_inverse_quant_seq.sv
// Self-checking bench for inverse_quant_seq: directed cases plus randomized
// blocks, rows compared against an arithmetic dequantisation model.
`timescale 1ns/1ps
module tb_inverse_quant_seq;

    localparam int V0 [6] = '{10, 11, 13, 14, 16, 18};
    localparam int V1 [6] = '{16, 18, 20, 23, 25, 29};
    localparam int V2 [6] = '{13, 14, 16, 18, 20, 23};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  block_type;
    logic [5:0]  qp_luma, qp_chroma;
    logic [15:0] dc_in;
    logic        all_zero;
    logic        coeff_rd_en;
    logic [1:0]  coeff_rd_row;
    logic [15:0] rd_d0 = '0, rd_d1 = '0, rd_d2 = '0, rd_d3 = '0;
    logic        out_valid, out_ready, out_last, busy, done, err;
    logic [1:0]  out_row;
    logic [15:0] out_p_0, out_p_1, out_p_2, out_p_3;

    logic [15:0] mem [4][4];
    int n_cmp = 0;
    int n_bad = 0;
    int n_rd  = 0;

    inverse_quant_seq dut (
        .clk (clk), .rst_n (rst_n), .start (start), .block_type (block_type),
        .qp_luma (qp_luma), .qp_chroma (qp_chroma), .dc_in (dc_in), .all_zero (all_zero),
        .coeff_rd_en (coeff_rd_en), .coeff_rd_row (coeff_rd_row),
        .coeff_rd_data_0 (rd_d0), .coeff_rd_data_1 (rd_d1),
        .coeff_rd_data_2 (rd_d2), .coeff_rd_data_3 (rd_d3),
        .out_valid (out_valid), .out_ready (out_ready), .out_row (out_row), .out_last (out_last),
        .out_p_0 (out_p_0), .out_p_1 (out_p_1), .out_p_2 (out_p_2), .out_p_3 (out_p_3),
        .busy (busy), .done (done), .err (err)
    );

    always #5 clk = ~clk;

    // Coefficient buffer: registered read, one-cycle latency
    always @(posedge clk) begin
        if (coeff_rd_en) begin
            rd_d0 <= mem[coeff_rd_row][0];
            rd_d1 <= mem[coeff_rd_row][1];
            rd_d2 <= mem[coeff_rd_row][2];
            rd_d3 <= mem[coeff_rd_row][3];
            n_rd  <= n_rd + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected dequantised value of one coefficient
    function automatic logic [15:0] model(input logic [2:0] bt, input int qp, input logic [15:0] dc,
                                          input int row, input int col, input logic [15:0] c);
        longint val;
        int     ls;
        if ((bt == 3'd2 || bt == 3'd6) && row == 0 && col == 0) return dc;
        if (bt == 3'd1 || bt == 3'd5 || (row % 2 == 0 && col % 2 == 0)) ls = V0[qp % 6];
        else if (row % 2 == 1 && col % 2 == 1)                         ls = V1[qp % 6];
        else                                                           ls = V2[qp % 6];
        val = longint'($signed(c)) * longint'(ls) * (longint'(1) << (qp / 6));
        if (bt == 3'd1)      val = val >>> 2;
        else if (bt == 3'd5) val = val >>> 1;
        return val[15:0];
    endfunction

    task automatic check_row(input logic [2:0] bt, input int qp, input logic [15:0] dc,
                             input int r, input int nrows);
        chk("out_row", 32'(out_row), 32'(r));
        chk("out_last", 32'(out_last), 32'(r == nrows - 1));
        chk("out_p_0", 32'(out_p_0), 32'(model(bt, qp, dc, r, 0, mem[r][0])));
        chk("out_p_1", 32'(out_p_1), 32'(model(bt, qp, dc, r, 1, mem[r][1])));
        chk("out_p_2", 32'(out_p_2), 32'(model(bt, qp, dc, r, 2, mem[r][2])));
        chk("out_p_3", 32'(out_p_3), 32'(model(bt, qp, dc, r, 3, mem[r][3])));
    endtask

    // Runs one block; cycle 0 is the cycle start is sampled in
    task automatic run_block(input logic [2:0] bt, input logic [5:0] ql, input logic [5:0] qc,
                             input logic [15:0] dc, input logic az, input int stall_pct,
                             input int hold0);
        int cyc, exp_cyc, nrows, qp, rd_base, guard, held, err_seen;
        bit skip, seen, acc;
        nrows = (bt == 3'd5) ? 1 : 4;
        qp    = (bt == 3'd5 || bt == 3'd6) ? int'(qc) : int'(ql);
        skip  = 1'b0;
`ifdef IQ_ZERO_SKIP_EN
        skip  = az;
`endif
        @(negedge clk);
        block_type = bt; qp_luma = ql; qp_chroma = qc; dc_in = dc; all_zero = az;
        start = 1'b1; out_ready = 1'b0;
        rd_base  = n_rd;
        err_seen = 0;
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        cyc     = 1;
        exp_cyc = skip ? 1 : 3;
        for (int r = 0; r < nrows; r++) begin
            seen = 0; acc = 0; guard = 0; held = 0;
            while (!acc && guard < 64) begin
                if (err) err_seen++;
                if (out_valid) begin
                    if (!seen) begin
                        chk("row_cycle", 32'(cyc), 32'(exp_cyc));
                        chk("done_early", 32'(done), 32'd0);
                        seen = 1;
                        if (r == 0) start = 1'($urandom_range(1));
                    end
                    check_row(bt, qp, dc, r, nrows);
                    chk("rd_while_valid", 32'(coeff_rd_en), 32'd0);
                    if (r == 0 && held < hold0) begin
                        out_ready = 1'b0;
                        held++;
                    end else begin
                        out_ready = ($urandom_range(99) >= stall_pct);
                    end
                    acc = out_ready;
                end else begin
                    out_ready = 1'($urandom_range(1));
                end
                @(posedge clk);
                @(negedge clk);
                start = 1'b0;
                cyc++;
                guard++;
            end
            if (!acc) chk("row_timeout", 32'd0, 32'd1);
            exp_cyc = skip ? cyc : cyc + 2;
        end
        if (err) err_seen++;
        out_ready = 1'b0;
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_after", 32'(busy), 32'd0);
        chk("rd_count", 32'(n_rd - rd_base), skip ? 32'd0 : 32'(nrows));
        chk("no_err_busy", 32'(err_seen), 32'd0);
        @(negedge clk);
        chk("done_once", 32'(done), 32'd0);
    endtask

    task automatic fill_mem(input int lo, input int hi);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                mem[r][c] = 16'($urandom_range(hi - lo) + lo);
    endtask

    task automatic clear_mem();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                mem[r][c] = 16'd0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [2:0] bts [5];
        logic [2:0] ill [3];
        int g, dn;
        bts = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6};
        ill = '{3'd0, 3'd4, 3'd7};
        rst_n = 1'b0; start = 1'b0; block_type = '0; qp_luma = '0; qp_chroma = '0;
        dc_in = '0; all_zero = 1'b0; out_ready = 1'b0;
        clear_mem();
        repeat (3) @(negedge clk);
        chk("reset_ctrl", 32'({out_valid, busy, done, err, coeff_rd_en, out_last, out_row}), 32'd0);
        chk("reset_p01", {out_p_0, out_p_1}, 32'd0);
        chk("reset_p23", {out_p_2, out_p_3}, 32'd0);
        rst_n = 1'b1;

        // Luma 4x4, all ones, qp 0, no stalls
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) mem[r][c] = 16'd1;
        run_block(3'd3, 6'd0, 6'd0, 16'd0, 1'b0, 0, 0);

        // Luma 4x4 qp 28, hold ready low at row 0
        clear_mem(); mem[0][0] = 16'd1;
        run_block(3'd3, 6'd28, 6'd0, 16'd0, 1'b0, 0, 5);

        // I16 AC with DC substitution
        clear_mem(); mem[0][0] = 16'd99; mem[1][2] = 16'd5;
        run_block(3'd2, 6'd28, 6'd0, 16'hFFF9, 1'b0, 0, 0);

        // Chroma DC single row
        clear_mem(); for (int c = 0; c < 4; c++) mem[0][c] = 16'd3;
        run_block(3'd5, 6'd0, 6'd12, 16'd0, 1'b0, 0, 0);

        // I16 luma DC
        clear_mem(); mem[0][0] = 16'd4;
        run_block(3'd1, 6'd0, 6'd0, 16'd0, 1'b0, 0, 0);

        // Illegal block types
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            block_type = ill[i]; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk("err_pulse", 32'(err), 32'd1);
            chk("err_busy", 32'(busy), 32'd0);
            @(negedge clk);
            chk("err_once", 32'({err, busy, coeff_rd_en}), 32'd0);
        end

        // All-zero blocks
        clear_mem();
        run_block(3'd6, 6'd10, 6'd30, 16'd123, 1'b1, 20, 2);
        run_block(3'd5, 6'd10, 6'd30, 16'd77, 1'b1, 0, 0);

        // Randomized blocks
        for (int n = 0; n < 24; n++) begin
            logic az;
            az = ($urandom_range(3) == 0);
            if (az) clear_mem(); else fill_mem(-200, 200);
            run_block(bts[$urandom_range(4)], 6'($urandom_range(51)), 6'($urandom_range(51)),
                      16'($urandom_range(2000)) - 16'd1000, az, 30, 0);
        end

        // Mid-block reset at row 2
        fill_mem(1, 50);
        @(negedge clk);
        block_type = 3'd3; qp_luma = 6'd20; all_zero = 1'b0; start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        g = 0;
        while (!(out_valid && out_row == 2'd2) && g < 40) begin
            @(negedge clk);
            g++;
        end
        chk("rst_reach_row2", 32'(out_valid && out_row == 2'd2), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ctrl", 32'({out_valid, busy, done, err, coeff_rd_en, out_last, out_row}), 32'd0);
        chk("rst_mid_p01", {out_p_0, out_p_1}, 32'd0);
        chk("rst_mid_p23", {out_p_2, out_p_3}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || busy || out_valid) dn++;
        end
        chk("rst_no_done", 32'(dn), 32'd0);
        run_block(3'd3, 6'd20, 6'd0, 16'd0, 1'b0, 25, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
